// File: rtl/serial_rx_deser.sv
// rtl/serial_rx_deser.sv - strobed serial frame receiver (start, LSB-first data, optional even parity, stop)
module serial_rx_deser #(
    parameter int DATA_W    = 8,
    parameter int PARITY_EN = 1
) (
    input  logic              ck,
    input  logic              rst_n,
    input  logic              sin,
    input  logic              bit_en,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] shift_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              par_bit;

    // Widened so the shift is a plain slice even when DATA_W is 1.
    logic [DATA_W:0]   shift_in;
    logic              par_bad;

    assign shift_in = {sin, shift_q};
    assign par_bad  = (PARITY_EN != 0) && (par_bit != (^shift_q));

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            par_bit    <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            if (bit_en) begin
                case (state)
                    S_IDLE: begin
                        if (!sin) begin
                            state   <= S_DATA;
                            shift_q <= '0;
                            cnt_q   <= '0;
                            par_bit <= 1'b0;
                            busy    <= 1'b1;
                        end
                    end
                    S_DATA: begin
                        shift_q <= shift_in[DATA_W:1];
                        cnt_q   <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_BIT) begin
                            if (PARITY_EN != 0) begin
                                state <= S_PARITY;
                            end else begin
                                state <= S_STOP;
                            end
                        end
                    end
                    S_PARITY: begin
                        par_bit <= sin;
                        state   <= S_STOP;
                    end
                    S_STOP: begin
                        if (sin) begin
                            data_out   <= shift_q;
                            data_valid <= 1'b1;
                            parity_err <= par_bad;
                            busy       <= 1'b0;
                            state      <= S_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= S_BREAK;
                        end
                    end
                    S_BREAK: begin
                        // The release-high sample only ends the break; it cannot start a frame.
                        if (sin) begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_serial_rx_deser.sv
// tb/tb_serial_rx_deser.sv - directed-vector bench for serial_rx_deser (parity and no-parity builds)
module tb_serial_rx_deser;
    logic       ck = 1'b0;
    logic       rst_n = 1'b0;
    logic       sin = 1'b1;
    logic       bit_en = 1'b0;
    logic [7:0] data_out;
    logic       data_valid, parity_err, frame_err, busy;
    logic [7:0] data_out_np;
    logic       data_valid_np, parity_err_np, frame_err_np, busy_np;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_cyc = 0;
    int start_cyc = 0;

    int dv_cnt = 0, pe_cnt = 0, pe_dv_cnt = 0, fe_cnt = 0, busy_cnt = 0, dv_cyc = 0;
    int dv_np_cnt = 0, dv_np_cyc = 0;
    logic [7:0] np_data_prev = 8'h00, np_data_last = 8'h00;

    int s_dv, s_pe, s_pe_dv, s_fe, s_busy, s_dv_np;

    serial_rx_deser #(.DATA_W(8), .PARITY_EN(1)) dut (
        .ck(ck), .rst_n(rst_n), .sin(sin), .bit_en(bit_en),
        .data_out(data_out), .data_valid(data_valid), .parity_err(parity_err),
        .frame_err(frame_err), .busy(busy)
    );

    serial_rx_deser #(.DATA_W(8), .PARITY_EN(0)) dut_np (
        .ck(ck), .rst_n(rst_n), .sin(sin), .bit_en(bit_en),
        .data_out(data_out_np), .data_valid(data_valid_np), .parity_err(parity_err_np),
        .frame_err(frame_err_np), .busy(busy_np)
    );

    always #5 ck = ~ck;

    always @(posedge ck) cyc <= cyc + 1;

    always @(negedge ck) begin
        if (data_valid) begin
            dv_cnt = dv_cnt + 1;
            dv_cyc = cyc;
        end
        if (parity_err) pe_cnt = pe_cnt + 1;
        if (parity_err && data_valid) pe_dv_cnt = pe_dv_cnt + 1;
        if (frame_err) fe_cnt = fe_cnt + 1;
        if (busy) busy_cnt = busy_cnt + 1;
        if (data_valid_np) begin
            dv_np_cnt    = dv_np_cnt + 1;
            dv_np_cyc    = cyc;
            np_data_prev = np_data_last;
            np_data_last = data_out_np;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        s_dv    = dv_cnt;
        s_pe    = pe_cnt;
        s_pe_dv = pe_dv_cnt;
        s_fe    = fe_cnt;
        s_busy  = busy_cnt;
        s_dv_np = dv_np_cnt;
    endtask

    task automatic strobe(input logic b, input int gap);
        @(negedge ck);
        sin    = b;
        bit_en = 1'b1;
        @(posedge ck);
        #1 last_cyc = cyc;
        repeat (gap) begin
            @(negedge ck);
            bit_en = 1'b0;
            @(posedge ck);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge ck);
            bit_en = 1'b0;
            sin    = 1'b1;
            @(posedge ck);
        end
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit with_par, input logic par,
                              input logic stop, input int gap);
        strobe(1'b0, gap);
        start_cyc = last_cyc;
        for (int i = 0; i < 8; i++) strobe(d[i], gap);
        if (with_par) strobe(par, gap);
        strobe(stop, gap);
    endtask

    initial begin
        // Reset values
        repeat (3) @(posedge ck);
        #1;
        check("rst_data_out", 32'(data_out), 32'h00);
        check("rst_data_valid", 32'(data_valid), 32'h0);
        check("rst_parity_err", 32'(parity_err), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        @(negedge ck);
        rst_n = 1'b1;
        idle(2);

        // Good frame 0xA5, parity 0
        snap();
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 0);
        idle(3);
        check("good_data", 32'(data_out), 32'hA5);
        check("good_dv_count", 32'(dv_cnt - s_dv), 32'd1);
        check("good_pe_count", 32'(pe_cnt - s_pe), 32'd0);
        check("good_fe_count", 32'(fe_cnt - s_fe), 32'd0);
        check("good_busy_cycles", 32'(busy_cnt - s_busy), 32'd10);
        check("good_latency", 32'(dv_cyc - start_cyc), 32'd10);

        // Parity error: 0x3C has even ones, so parity bit 1 is wrong
        snap();
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 0);
        idle(3);
        check("perr_data", 32'(data_out), 32'h3C);
        check("perr_dv_count", 32'(dv_cnt - s_dv), 32'd1);
        check("perr_with_dv", 32'(pe_dv_cnt - s_pe_dv), 32'd1);
        check("perr_fe_count", 32'(fe_cnt - s_fe), 32'd0);

        // Framing error then break of 3 low strobes
        snap();
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 3; i++) strobe(1'b0, 0);
        @(negedge ck);
        bit_en = 1'b0;
        check("ferr_busy_in_break", 32'(busy), 32'h1);
        strobe(1'b1, 0);
        @(negedge ck);
        bit_en = 1'b0;
        check("ferr_busy_released", 32'(busy), 32'h0);
        idle(3);
        check("ferr_fe_count", 32'(fe_cnt - s_fe), 32'd1);
        check("ferr_dv_count", 32'(dv_cnt - s_dv), 32'd0);
        check("ferr_data_held", 32'(data_out), 32'h3C);

        // Strobe every 4th cycle, 0x81
        snap();
        send_frame(8'h81, 1'b1, 1'b0, 1'b1, 3);
        idle(3);
        check("gap_data", 32'(data_out), 32'h81);
        check("gap_dv_count", 32'(dv_cnt - s_dv), 32'd1);
        check("gap_latency", 32'(dv_cyc - start_cyc), 32'd40);

        // Asynchronous reset after 4 data bits
        strobe(1'b0, 0);
        for (int i = 0; i < 4; i++) strobe(1'b1, 0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_data_out", 32'(data_out), 32'h00);
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_flags", 32'({data_valid, parity_err, frame_err}), 32'h0);
        @(negedge ck);
        bit_en = 1'b0;
        sin    = 1'b1;
        rst_n  = 1'b1;
        idle(2);
        snap();
        send_frame(8'hFF, 1'b1, 1'b0, 1'b1, 0);
        idle(3);
        check("arst_next_data", 32'(data_out), 32'hFF);
        check("arst_next_dv", 32'(dv_cnt - s_dv), 32'd1);
        check("arst_next_pe", 32'(pe_cnt - s_pe), 32'd0);

        // Back-to-back frames on the no-parity instance
        @(negedge ck);
        rst_n = 1'b0;
        @(negedge ck);
        rst_n = 1'b1;
        idle(2);
        snap();
        send_frame(8'h12, 1'b0, 1'b0, 1'b1, 0);
        send_frame(8'h34, 1'b0, 1'b0, 1'b1, 0);
        idle(3);
        check("b2b_dv_count", 32'(dv_np_cnt - s_dv_np), 32'd2);
        check("b2b_first_data", 32'(np_data_prev), 32'h12);
        check("b2b_second_data", 32'(np_data_last), 32'h34);
        check("b2b_second_latency", 32'(dv_np_cyc - start_cyc), 32'd9);
        check("b2b_parity_err", 32'(parity_err_np), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
